// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream loader that programs instruction memory while holding the core in reset
module imem_loader #(
  parameter int unsigned DEPTH_WORDS = 16,
  parameter logic [63:0] BASE_ADDR   = 64'd0,
  parameter int unsigned RESET_HOLD  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] num_words,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [63:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_RELEASE,
    S_DONE
  } state_t;

  state_t      r_state;
  logic        r_byte_ready;
  logic        r_imem_we;
  logic [63:0] r_imem_addr;
  logic [31:0] r_imem_wdata;
  logic        r_cpu_reset;
  logic        r_done;
  logic        r_error;
  logic [23:0] r_asm;
  logic [1:0]  r_byte_idx;
  logic [15:0] r_word_idx;
  logic [15:0] r_count;
  logic [31:0] r_hold;

  logic        w_xfer;
  logic        w_count_bad;
  logic        w_can_start;
  logic [63:0] w_word_addr;
  logic        w_hold_last;

  assign w_xfer      = byte_valid & r_byte_ready;
  assign w_count_bad = (num_words == 16'd0) || ({16'd0, num_words} > DEPTH_WORDS);
  assign w_can_start = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_word_addr = BASE_ADDR + {46'd0, r_word_idx, 2'b00};
  // A RESET_HOLD of 0 still spends one cycle in RELEASE.
  assign w_hold_last = ((r_hold + 32'd1) >= RESET_HOLD);

  assign byte_ready = r_byte_ready;
  assign imem_we    = r_imem_we;
  assign imem_addr  = r_imem_addr;
  assign imem_wdata = r_imem_wdata;
  assign cpu_reset  = r_cpu_reset;
  assign done       = r_done;
  assign error      = r_error;

  // Load sequencer: validate start, gather 4 bytes, pulse a word write, then hold and release the core.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_byte_ready <= 1'b0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= 64'd0;
      r_imem_wdata <= 32'd0;
      r_cpu_reset  <= 1'b1;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_asm        <= 24'd0;
      r_byte_idx   <= 2'd0;
      r_word_idx   <= 16'd0;
      r_count      <= 16'd0;
      r_hold       <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start && w_can_start) begin
            if (w_count_bad) begin
              // Rejected start leaves state and cpu_reset alone.
              r_error <= 1'b1;
              r_done  <= 1'b0;
            end else begin
              r_count      <= num_words;
              r_error      <= 1'b0;
              r_done       <= 1'b0;
              r_cpu_reset  <= 1'b1;
              r_word_idx   <= 16'd0;
              r_byte_idx   <= 2'd0;
              r_byte_ready <= 1'b1;
              r_state      <= S_COLLECT;
            end
          end
        end
        S_COLLECT: begin
          if (w_xfer) begin
            case (r_byte_idx)
              2'd0: r_asm[7:0]   <= byte_in;
              2'd1: r_asm[15:8]  <= byte_in;
              2'd2: r_asm[23:16] <= byte_in;
              default: begin
                // Fourth byte completes the word; present it directly to memory.
                r_imem_wdata <= {byte_in, r_asm};
                r_imem_addr  <= w_word_addr;
                r_imem_we    <= 1'b1;
                r_byte_ready <= 1'b0;
                r_state      <= S_WRITE;
              end
            endcase
            r_byte_idx <= r_byte_idx + 2'd1;
          end
        end
        S_WRITE: begin
          r_imem_we  <= 1'b0;
          r_word_idx <= r_word_idx + 16'd1;
          if ((r_word_idx + 16'd1) == r_count) begin
            r_hold  <= 32'd0;
            r_state <= S_RELEASE;
          end else begin
            r_byte_idx   <= 2'd0;
            r_byte_ready <= 1'b1;
            r_state      <= S_COLLECT;
          end
        end
        S_RELEASE: begin
          if (w_hold_last) begin
            r_cpu_reset <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_hold <= r_hold + 32'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
module tb_imem_loader;

  localparam int unsigned DEPTH = 16;
  localparam logic [63:0] BASE  = 64'd0;
  localparam int unsigned HOLD  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] num_words;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        imem_we;
  logic [63:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;

  imem_loader #(
    .DEPTH_WORDS(DEPTH),
    .BASE_ADDR  (BASE),
    .RESET_HOLD (HOLD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .num_words (num_words),
    .byte_in   (byte_in),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_reset (cpu_reset),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    int          nw;
    bit          gap;
    bit          err;
    bit          stray;
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vecs[7];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_we_cyc = 0;
  bit   prev_we = 1'b0;
  logic exp_cpu_reset = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard: every write strobe must match the next expected (addr, data) pair.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      chk("we_single_cycle", {63'd0, prev_we}, 64'd0);
      chk("cpu_reset_during_write", {63'd0, cpu_reset}, 64'd1);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write addr=%0h data=%0h required=none", imem_addr, imem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_addr", imem_addr, e.a);
        chk("write_data", {32'd0, imem_wdata}, {32'd0, e.d});
      end
      last_we_cyc = cyc;
    end
    prev_we = (imem_we === 1'b1);
  end

  function automatic logic [31:0] word_of(input vec_t v, input int i);
    if (i == 0) return v.w0;
    if (i == 1) return v.w1;
    return v.w0 ^ (32'(i) * 32'h9E3779B9);
  endfunction

  task automatic check_reset_vals();
    chk("rst_byte_ready", {63'd0, byte_ready}, 64'd0);
    chk("rst_imem_we", {63'd0, imem_we}, 64'd0);
    chk("rst_imem_addr", imem_addr, 64'd0);
    chk("rst_imem_wdata", {32'd0, imem_wdata}, 64'd0);
    chk("rst_cpu_reset", {63'd0, cpu_reset}, 64'd1);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_error", {63'd0, error}, 64'd0);
  endtask

  task automatic do_start(input int n);
    start = 1'b1;
    num_words = 16'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int budget;
    if (gap) begin
      byte_valid = 1'b0;
      byte_in = 8'($urandom);
      @(negedge clk);
    end
    byte_in = b;
    byte_valid = 1'b1;
    budget = 0;
    while (byte_ready !== 1'b1 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (byte_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL byte_ready_timeout actual=%b required=1", byte_ready);
    end
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    int budget;
    logic [31:0] w;
    do_start(v.nw);
    if (v.err) begin
      chk("bad_error", {63'd0, error}, 64'd1);
      chk("bad_done", {63'd0, done}, 64'd0);
      chk("bad_cpu_reset", {63'd0, cpu_reset}, {63'd0, exp_cpu_reset});
      chk("bad_byte_ready", {63'd0, byte_ready}, 64'd0);
      repeat (3) @(negedge clk);
      chk("bad_stays_idle", {63'd0, byte_ready}, 64'd0);
      chk("bad_error_sticky", {63'd0, error}, 64'd1);
      return;
    end
    chk("start_cpu_reset", {63'd0, cpu_reset}, 64'd1);
    chk("start_done", {63'd0, done}, 64'd0);
    chk("start_error", {63'd0, error}, 64'd0);
    chk("start_byte_ready", {63'd0, byte_ready}, 64'd1);
    for (int i = 0; i < v.nw; i++) begin
      wr_t e;
      w = word_of(v, i);
      e.a = BASE + 64'(4 * i);
      e.d = w;
      exp_q.push_back(e);
      for (int k = 0; k < 4; k++) begin
        send_byte(w[8*k +: 8], v.gap);
        if (v.stray && i == 0 && k == 1) begin
          byte_valid = 1'b0;
          do_start(5);
          chk("stray_error", {63'd0, error}, 64'd0);
        end
      end
      chk("write_latency_we", {63'd0, imem_we}, 64'd1);
      chk("write_latency_ready", {63'd0, byte_ready}, 64'd0);
      byte_valid = 1'b0;
      @(negedge clk);
      chk("ready_after_write", {63'd0, byte_ready}, {63'd0, (i != v.nw - 1)});
    end
    budget = 0;
    while (done !== 1'b1 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    chk("done_set", {63'd0, done}, 64'd1);
    chk("release_cpu_reset", {63'd0, cpu_reset}, 64'd0);
    chk("release_delay", 64'(cyc - last_we_cyc), 64'(HOLD + 1));
    chk("all_writes_seen", 64'(exp_q.size()), 64'd0);
    exp_cpu_reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;
    vecs[0] = '{nw: 0,  gap: 0, err: 1, stray: 0, w0: 32'h0,        w1: 32'h0};
    vecs[1] = '{nw: 2,  gap: 0, err: 0, stray: 0, w0: 32'h00A00513, w1: 32'h00B00593};
    vecs[2] = '{nw: 2,  gap: 1, err: 0, stray: 0, w0: 32'h00A00513, w1: 32'h00B00593};
    vecs[3] = '{nw: 17, gap: 0, err: 1, stray: 0, w0: 32'h0,        w1: 32'h0};
    vecs[4] = '{nw: 1,  gap: 1, err: 0, stray: 0, w0: 32'h12345678, w1: 32'h0};
    vecs[5] = '{nw: 16, gap: 0, err: 0, stray: 0, w0: 32'hCAFEF00D, w1: 32'h0BADC0DE};
    vecs[6] = '{nw: 2,  gap: 0, err: 0, stray: 1, w0: 32'h11223344, w1: 32'h55667788};

    reset = 1'b1;
    start = 1'b0;
    num_words = 16'd0;
    byte_in = 8'd0;
    byte_valid = 1'b0;
    @(negedge clk);
    check_reset_vals();
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 7; v++) run_vec(vecs[v]);

    // Reset in the middle of a word discards the partial bytes.
    do_start(1);
    send_byte(8'hEF, 1'b0);
    send_byte(8'hBE, 1'b0);
    byte_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals();
    reset = 1'b0;
    exp_cpu_reset = 1'b1;
    @(negedge clk);
    rv = '{nw: 1, gap: 0, err: 0, stray: 0, w0: 32'hDEADBEEF, w1: 32'h0};
    run_vec(rv);

    repeat (3) @(negedge clk);
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream writer that programs the RISC-V core's instruction memory before execution.
- Holds the processor in reset while loading, then releases it to fetch from BASE_ADDR.
- Assembles little-endian bytes from a valid/ready source into 32-bit instruction words.
- Issues single-cycle word writes at consecutive word addresses.

Parameters:
- DEPTH_WORDS, 16, instruction memory capacity in 32-bit words.
- BASE_ADDR, 64'd0, byte address of the first instruction written.
- RESET_HOLD, 2, cycles cpu_reset stays high after the last write.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a load; honoured only in IDLE or DONE.
- num_words  input  16  instruction count; latched when start is accepted.
- byte_in  input  8  stream data byte.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader accepts a byte this cycle.
- imem_we  output  1  instruction memory write strobe.
- imem_addr  output  64  instruction memory byte address.
- imem_wdata  output  32  instruction word to write.
- cpu_reset  output  1  reset to RISC_V_Processor; high while loading.
- done  output  1  load complete; sticky until the next accepted start.
- error  output  1  last start rejected; sticky until the next accepted start.

Behaviour:
- Reset values (asynchronous): state=IDLE, byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, done=0, error=0. Byte index, word index and hold counter all clear to 0.
- Handshake: a byte transfers only in a cycle with byte_valid=1 and byte_ready=1. byte_valid while byte_ready=0 is ignored; no transfer occurs.
- Byte ordering: byte k (k=0..3) of a word goes to imem_wdata[8k+7:8k], little-endian.
- IDLE/DONE, start=1, num_words==0 or num_words>DEPTH_WORDS:
  - error=1, done=0, no write.
  - State unchanged; cpu_reset unchanged (stays 1 from IDLE).
- IDLE/DONE, start=1, valid count:
  - Latch num_words; clear error and done; cpu_reset=1; word_idx=0.
  - Go to COLLECT; byte_ready=1 from the next cycle.
- COLLECT:
  - Accept bytes until 4 are held.
  - In the cycle the 4th byte is accepted, byte_ready drops next edge and the state goes to WRITE.
- WRITE:
  - Exactly one cycle with imem_we=1, imem_addr=BASE_ADDR+4*word_idx, imem_wdata=assembled word.
  - Latency: 4th byte accepted in cycle N -> imem_we high in cycle N+1 -> byte_ready high again in cycle N+2.
  - Then word_idx+1. If it equals the latched count, go to RELEASE; else go to COLLECT with byte_idx=0.
- RELEASE:
  - cpu_reset held 1 for RESET_HOLD cycles.
  - Then cpu_reset=0, done=1, state=DONE.
- imem_we is 0 in every state except WRITE. imem_addr/imem_wdata hold their last values outside WRITE.
- start during COLLECT/WRITE/RELEASE is ignored.
- start in DONE starts a reload: cpu_reset returns to 1 on the edge that accepts start.
- Reset mid-load: immediate return to reset values; partially collected bytes are discarded. Words already written remain in memory; the loader does not clear memory.
- Address arithmetic: 64-bit, no wrap. The bound check on num_words guarantees the last address is BASE_ADDR+4*(DEPTH_WORDS-1).

Test Plan:
- Basic load: num_words=2, start, bytes 13 05 A0 00 93 05 B0 00 with byte_valid held high.
  -> Writes (0x0, 0x00A00513) and (0x4, 0x00B00593).
  -> cpu_reset falls RESET_HOLD=2 cycles after RELEASE entry; done=1.
- Gappy source: same bytes with byte_valid high every other cycle.
  -> Identical two writes, no duplicates; imem_we is a 1-cycle pulse each time.
- Bad counts: num_words=0 -> error=1, no imem_we, cpu_reset=1. num_words=17 (DEPTH_WORDS=16) -> same.
  -> A following valid start clears error.
- Reset mid-word: assert reset after 2 bytes.
  -> All outputs at reset values. A new start with bytes EF BE AD DE writes 0xDEADBEEF to address 0.
- Full capacity: 16 words.
  -> Last write at imem_addr=60; done=1.
- Stray start and reload: start pulsed during COLLECT -> no effect on counts.
  -> start pulsed in DONE: cpu_reset returns to 1, done=0, and a reload writes again from address 0.
